// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO debounce / glitch filter bank.
//   cnt_width()         : width of a channel's stability counter (clog2, min 1 bit)
//   GPIO_SYNC_STAGES    : default synchroniser depth
//   GPIO_STABLE_CNT     : default number of differing samples before a flip
//   gpio_cnt_t          : counter type wide enough for the largest legal depth
package gpio_pkg;

  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_STABLE_CNT  = 2;
  // STABLE_CNT may be as large as 256, so the counter never needs more than 8 bits.
  localparam int GPIO_CNT_MAX_W   = 8;

  typedef logic [GPIO_CNT_MAX_W-1:0] gpio_cnt_t;

  // Counter only has to reach STABLE_CNT-1; a depth of 1 or 2 still gets one bit.
  function automatic int cnt_width(input int stable_cnt);
    return (stable_cnt <= 2) ? 1 : $clog2(stable_cnt);
  endfunction

endpackage

// File: rtl/gpio_filter_chan.sv
// gpio_filter_chan: one debounce channel.
//   clk, reset_n : system clock, asynchronous active-low reset
//   din          : raw pad input (asynchronous to clk)
//   ena          : sample strobe, counter/filter advance only when high
//   hold         : freeze dout while high
//   dout         : filtered (and optionally frozen) level
//   rise, fall   : one-clk strobes following a filtered 0->1 / 1->0 transition
//   edge_next    : combinational "filter flips on this edge", lets the parent
//                  register an aggregate strobe aligned with rise/fall
module gpio_filter_chan
  import gpio_pkg::*;
#(
  parameter int   STABLE_CNT  = GPIO_STABLE_CNT,
  parameter int   SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic ena,
  input  logic hold,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic edge_next
);

  localparam int        CNT_W    = cnt_width(STABLE_CNT);
  localparam gpio_cnt_t CNT_LAST = gpio_cnt_t'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   r_filt;
  logic                   w_filt_next;
  logic                   r_held;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // A run of differing samples survives non-ena cycles; only an ena sample
  // that agrees with the current filtered level restarts it.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_filt_next = r_filt;
    if (ena) begin
      if (w_s == r_filt) begin
        w_cnt_next = '0;
      end else if (gpio_cnt_t'(r_cnt) == CNT_LAST) begin
        w_filt_next = w_s;
        w_cnt_next  = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_cnt  <= '0;
      r_filt <= RESET_VAL;
      r_held <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_cnt  <= w_cnt_next;
      r_filt <= w_filt_next;
      r_rise <= w_filt_next & ~r_filt;
      r_fall <= ~w_filt_next & r_filt;
      // Capturing the filter's next value keeps dout aligned with the edge
      // strobes, so a step lands SYNC_STAGES+STABLE_CNT clks after din moves.
      if (!hold) begin
        r_held <= w_filt_next;
      end
    end
  end

  assign dout      = r_held;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign edge_next = w_filt_next ^ r_filt;

endmodule

// File: rtl/gpio_filter_bank.sv
// gpio_filter_bank: WIDTH independent debounce channels with edge strobes.
//   clk, reset_n : system clock, asynchronous active-low reset
//   din          : raw pad inputs [WIDTH]
//   ena          : shared sample strobe from the prescaler
//   hold         : freeze dout (filters keep running)
//   dout         : filtered levels [WIDTH]
//   rise, fall   : per-channel one-clk edge strobes [WIDTH]
//   any_change   : OR of all rise/fall strobes, same cycle as them
module gpio_filter_bank
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STABLE_CNT  = GPIO_STABLE_CNT,
  parameter int               SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             ena,
  input  logic             hold,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [WIDTH-1:0] w_edge_next;
  logic             r_any;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      gpio_filter_chan #(
        .STABLE_CNT  (STABLE_CNT),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL[gi])
      ) u_chan (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din[gi]),
        .ena       (ena),
        .hold      (hold),
        .dout      (dout[gi]),
        .rise      (rise[gi]),
        .fall      (fall[gi]),
        .edge_next (w_edge_next[gi])
      );
    end
  endgenerate

  // Registered from the channels' next-edge indications so it rises in the
  // same cycle as the rise/fall strobes rather than one later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_edge_next;
    end
  end

  assign any_change = r_any;

endmodule
